// File: rtl/ysyx_23060077_rd_arbiter_pkg.sv
// Shared AXI constants and arbiter FSM state type.
package ysyx_23060077_rd_arbiter_pkg;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } rd_state_e;
endpackage

// File: rtl/ysyx_23060077_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
module ysyx_23060077_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_id,
  output logic [1:0] grant
);
  // Index of the client that won most recently; reset so client 0 wins first.
  logic last_q;

  // Pointer moves to the finished burst's owner on the update strobe.
  always_ff @(posedge clock) begin
    if (reset)       last_q <= 1'b1;
    else if (update) last_q <= upd_id;
  end

  // Contention goes to the client that did not win last; otherwise the sole requester.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    else              grant = req;
  end
endmodule

// File: rtl/ysyx_23060077_rd_arbiter.sv
// Two-client AXI read arbiter: I-cache refill (c0) and LSU load (c1) share one AR/R master.
module ysyx_23060077_rd_arbiter
  import ysyx_23060077_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_valid_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [LEN_W-1:0]  c0_len_i,
  output logic              c0_ready_o,
  output logic [DATA_W-1:0] c0_data_o,
  output logic              c0_last_o,
  output logic              c0_err_o,
  input  logic              c1_valid_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [LEN_W-1:0]  c1_len_i,
  output logic              c1_ready_o,
  output logic [DATA_W-1:0] c1_data_o,
  output logic              c1_last_o,
  output logic              c1_err_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [LEN_W-1:0]  arlen_o,
  output logic [ID_W-1:0]   arid_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic [ID_W-1:0]   rid_i
);
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              grant_q;
  logic [1:0]        gnt;
  logic              take;
  logic              beat;
  logic              burst_done;

  // Beats are routed by the latched grant alone, so the returned ID is not needed.
  logic unused_rid;
  assign unused_rid = ^rid_i;

  assign take       = (state_q == S_IDLE) && (c0_valid_i || c1_valid_i);
  assign beat       = (state_q == S_DATA) && rvalid_i;
  assign burst_done = beat && rlast_i;

  ysyx_23060077_rr_arb2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({c1_valid_i, c0_valid_i}),
    .update (burst_done),
    .upd_id (grant_q),
    .grant  (gnt)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: one burst in flight, back to IDLE on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ADDR;
      S_ADDR:  if (arready_i) state_d = S_DATA;
      S_DATA:  if (burst_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the winner's request when leaving IDLE; held stable through ADDR.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      grant_q <= 1'b0;
    end else if (take) begin
      addr_q  <= gnt[1] ? c1_addr_i : c0_addr_i;
      len_q   <= gnt[1] ? c1_len_i  : c0_len_i;
      grant_q <= gnt[1];
    end
  end

  assign arvalid_o = (state_q == S_ADDR);
  assign araddr_o  = addr_q;
  assign arlen_o   = len_q;
  assign arid_o    = {{(ID_W-1){1'b0}}, grant_q};
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;
  assign rready_o  = (state_q == S_DATA);

  // Steer each R beat to the granted client; the other sees zeros.
  always_comb begin
    c0_ready_o = 1'b0;
    c0_data_o  = '0;
    c0_last_o  = 1'b0;
    c0_err_o   = 1'b0;
    c1_ready_o = 1'b0;
    c1_data_o  = '0;
    c1_last_o  = 1'b0;
    c1_err_o   = 1'b0;
    if (beat) begin
      if (grant_q) begin
        c1_ready_o = 1'b1;
        c1_data_o  = rdata_i;
        c1_last_o  = rlast_i;
        c1_err_o   = (rresp_i != AXI_RESP_OKAY);
      end else begin
        c0_ready_o = 1'b1;
        c0_data_o  = rdata_i;
        c0_last_o  = rlast_i;
        c0_err_o   = (rresp_i != AXI_RESP_OKAY);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Bench for the two-client read arbiter: burst-level model plus directed literal checks.
module tb_ysyx_23060077_rd_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 8, ID_W = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic c0_valid_i = 0, c1_valid_i = 0;
  logic [ADDR_W-1:0] c0_addr_i = '0, c1_addr_i = '0;
  logic [LEN_W-1:0]  c0_len_i = '0, c1_len_i = '0;
  logic c0_ready_o, c0_last_o, c0_err_o, c1_ready_o, c1_last_o, c1_err_o;
  logic [DATA_W-1:0] c0_data_o, c1_data_o;
  logic arvalid_o, arready_i = 0, rready_o, rvalid_i = 0, rlast_i = 0;
  logic [ADDR_W-1:0] araddr_o;
  logic [LEN_W-1:0]  arlen_o;
  logic [ID_W-1:0]   arid_o, rid_i = '0;
  logic [2:0]        arsize_o;
  logic [1:0]        arburst_o, rresp_i = '0;
  logic [DATA_W-1:0] rdata_i = '0;

  ysyx_23060077_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .c0_valid_i(c0_valid_i), .c0_addr_i(c0_addr_i), .c0_len_i(c0_len_i),
    .c0_ready_o(c0_ready_o), .c0_data_o(c0_data_o), .c0_last_o(c0_last_o), .c0_err_o(c0_err_o),
    .c1_valid_i(c1_valid_i), .c1_addr_i(c1_addr_i), .c1_len_i(c1_len_i),
    .c1_ready_o(c1_ready_o), .c1_data_o(c1_data_o), .c1_last_o(c1_last_o), .c1_err_o(c1_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arid_o(arid_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rid_i(rid_i)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Burst-level model: is an AR pending, is a burst returning data, who owns it, who won last.
  bit m_valid = 0;
  bit m_ar_pending = 0, m_in_burst = 0;
  int m_owner = 0, m_last_winner = 1;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1; m_ar_pending = 0; m_in_burst = 0; m_last_winner = 1;
    end else if (m_ar_pending) begin
      if (arready_i) begin m_ar_pending = 0; m_in_burst = 1; end
    end else if (m_in_burst) begin
      if (rvalid_i && rlast_i) begin m_in_burst = 0; m_last_winner = m_owner; end
    end else if (c0_valid_i || c1_valid_i) begin
      if (c0_valid_i && c1_valid_i) m_owner = 1 - m_last_winner;
      else                          m_owner = c1_valid_i ? 1 : 0;
      m_addr = (m_owner == 1) ? c1_addr_i : c0_addr_i;
      m_len  = (m_owner == 1) ? c1_len_i  : c0_len_i;
      m_ar_pending = 1;
    end
  end

  // Compare every cycle, mid-period, against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      logic b0, b1;
      b0 = m_in_burst && rvalid_i && (m_owner == 0);
      b1 = m_in_burst && rvalid_i && (m_owner == 1);
      check("arvalid", arvalid_o, m_ar_pending);
      check("rready", rready_o, m_in_burst);
      if (m_ar_pending)
        check("ar_fields", {araddr_o, arlen_o, arid_o, arsize_o, arburst_o},
              {m_addr, m_len, ID_W'(m_owner), 3'b010, 2'b01});
      check("c0_beat", {c0_ready_o, c0_data_o, c0_last_o, c0_err_o},
            {b0, b0 ? rdata_i : 32'h0, b0 & rlast_i, b0 & (rresp_i != 2'b00)});
      check("c1_beat", {c1_ready_o, c1_data_o, c1_last_o, c1_err_o},
            {b1, b1 ? rdata_i : 32'h0, b1 & rlast_i, b1 & (rresp_i != 2'b00)});
    end
  end

  int arids[$];

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Wait (bounded) for arvalid, hold arready low for 'delay' cycles, then accept.
  task automatic serve_ar(input int delay);
    int n = 0;
    while (!arvalid_o && n < 20) begin tick(); n++; end
    if (!arvalid_o) begin check("ar_timeout", 0, 1); return; end
    repeat (delay) tick();
    arready_i = 1;
    arids.push_back(int'(arid_o));
    tick();
    arready_i = 0;
  endtask

  // Drive n R beats; rresp=2'b10 on beat err_idx (use -1 for none).
  task automatic send_beats(input int n, input logic [31:0] base, input int err_idx);
    for (int i = 0; i < n; i++) begin
      rvalid_i = 1; rdata_i = base + i; rlast_i = (i == n - 1);
      rresp_i = (i == err_idx) ? 2'b10 : 2'b00;
      tick();
    end
    rvalid_i = 0; rlast_i = 0; rresp_i = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    int cnt, lastpos;
    logic [3:0] errs;
    do_reset();

    // Reset state
    check("rst_arvalid", arvalid_o, 1'b0);
    check("rst_ar", {araddr_o, arlen_o, arid_o}, '0);

    // Test 1: single c0 request, one beat
    c0_valid_i = 1; c0_addr_i = 32'h3000_0000; c0_len_i = 0;
    tick();
    check("t1_arvalid", arvalid_o, 1'b1);
    check("t1_araddr", araddr_o, 32'h3000_0000);
    arready_i = 1; tick(); arready_i = 0;
    c0_valid_i = 0;
    rvalid_i = 1; rdata_i = 32'hDEAD_BEEF; rlast_i = 1; #1;
    check("t1_c0", {c0_ready_o, c0_data_o, c0_last_o}, {1'b1, 32'hDEAD_BEEF, 1'b1});
    check("t1_c1", {c1_ready_o, c1_data_o, c1_last_o}, '0);
    tick(); rvalid_i = 0; rlast_i = 0;
    tick();

    // Test 2: simultaneous requests after reset -> c0 then c1
    do_reset();
    arids.delete();
    c0_valid_i = 1; c0_addr_i = 32'h100; c1_valid_i = 1; c1_addr_i = 32'h200;
    tick();
    serve_ar(0); c0_valid_i = 0; send_beats(1, 32'hA0, -1);
    check("t2_idle_gap", arvalid_o, 1'b0);
    serve_ar(0); c1_valid_i = 0; send_beats(1, 32'hB0, -1);
    check("t2_order", {arids.size(), arids[0], arids[1]}, {32'd2, 32'd0, 32'd1});
    tick();

    // Test 3: both requesting continuously -> 0,1,0,1
    arids.delete();
    c0_valid_i = 1; c1_valid_i = 1;
    for (int k = 0; k < 4; k++) begin
      serve_ar(0);
      if (k == 3) begin c0_valid_i = 0; c1_valid_i = 0; end
      send_beats(1, 32'hC0 + k, -1);
    end
    check("t3_alt", {arids[0], arids[1], arids[2], arids[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    tick();

    // Test 4: c1 len 3, arready delayed 5 cycles
    c1_valid_i = 1; c1_addr_i = 32'h8000_0040; c1_len_i = 3;
    tick();
    serve_ar(5);
    c1_valid_i = 0;
    cnt = 0; lastpos = -1;
    for (int i = 0; i < 4; i++) begin
      rvalid_i = 1; rdata_i = 32'h1000 + i; rlast_i = (i == 3); #1;
      if (c1_ready_o) cnt++;
      if (c1_last_o) lastpos = (lastpos == -1) ? i : 99;
      tick();
    end
    rvalid_i = 0; rlast_i = 0;
    check("t4_strobes", cnt, 4);
    check("t4_lastpos", lastpos, 3);
    tick();

    // Test 5: error response on the second of three beats
    c0_valid_i = 1; c0_addr_i = 32'h40; c0_len_i = 2;
    tick();
    serve_ar(0);
    c0_valid_i = 0;
    errs = '0;
    for (int i = 0; i < 3; i++) begin
      rvalid_i = 1; rdata_i = 32'h2000 + i; rlast_i = (i == 2);
      rresp_i = (i == 1) ? 2'b10 : 2'b00; #1;
      errs[i] = c0_err_o;
      tick();
    end
    rvalid_i = 0; rlast_i = 0; rresp_i = 0;
    check("t5_err", errs, 4'b0010);
    check("t5_done", rready_o, 1'b0);
    tick();

    // Test 6: reset mid-burst after 2 of 4 beats, then a fresh request
    c1_valid_i = 1; c1_addr_i = 32'h500; c1_len_i = 3;
    tick();
    serve_ar(0);
    c1_valid_i = 0;
    for (int i = 0; i < 2; i++) begin
      rvalid_i = 1; rdata_i = 32'h3000 + i; rlast_i = 0; tick();
    end
    rvalid_i = 0;
    reset = 1; tick(); reset = 0;
    check("t6_rst", {arvalid_o, rready_o, araddr_o, arlen_o, arid_o}, '0);
    rvalid_i = 1; rdata_i = 32'h3002; #1;
    check("t6_stray", {c0_ready_o, c1_ready_o, c1_data_o}, '0);
    rvalid_i = 0;
    c0_valid_i = 1; c0_addr_i = 32'h600; c0_len_i = 0;
    tick();
    check("t6_fresh_ar", {arvalid_o, araddr_o, arid_o}, {1'b1, 32'h600, 4'd0});
    serve_ar(0);
    c0_valid_i = 0;
    rvalid_i = 1; rdata_i = 32'h7777; rlast_i = 1; #1;
    check("t6_fresh_beat", {c0_ready_o, c0_data_o, c0_last_o}, {1'b1, 32'h7777, 1'b1});
    tick(); rvalid_i = 0; rlast_i = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
